// File: rtl/dot_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : dot_feeder
//  Description : Holds two element vectors (A and B) and streams them to an
//                external dot-product accumulator on request. The block then
//                captures the accumulator result and holds it for a
//                downstream consumer.
//  Revision    : 1.0  initial release
// ============================================================================
module dot_feeder #(
  parameter int MAX_LEN = 8,
  parameter int W       = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       wr_en_i,
  input  logic [$clog2(MAX_LEN)-1:0] wr_addr_i,
  input  logic [W-1:0]               wr_a_i,
  input  logic [W-1:0]               wr_b_i,
  input  logic                       start_i,
  input  logic [$clog2(MAX_LEN):0]   len_i,
  output logic [W-1:0]               A_o,
  output logic [W-1:0]               B_o,
  output logic                       A_v_o,
  output logic                       B_v_o,
  input  logic                       ready_i,
  output logic                       done_acc_o,
  input  logic [W-1:0]               accum_i,
  input  logic                       v_i,
  output logic                       yumi_o,
  output logic [W-1:0]               res_o,
  output logic                       res_v_o,
  input  logic                       res_ready_i,
  output logic                       busy_o
);

  localparam int              AW        = $clog2(MAX_LEN);
  localparam int              LW        = AW + 1;
  localparam logic [LW-1:0]   MAX_LEN_L = LW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_STREAM  = 3'd2,
    S_WAITRES = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   k_q, k_d;
  logic [LW-1:0]   len_q, len_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    bufa_q [MAX_LEN];
  logic [W-1:0]    bufb_q [MAX_LEN];
  logic            last_elem;

  // The final element is the one whose index equals the latched length minus one.
  assign last_elem = ({1'b0, k_q} == (len_q - LW'(1)));
  assign res_o     = res_q;

  // Vector buffers: cleared by reset and writable only while idle, so a
  // request in flight always streams a stable snapshot.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        bufa_q[i] <= '0;
        bufb_q[i] <= '0;
      end
    end else if (wr_en_i && (state_q == S_IDLE)) begin
      bufa_q[wr_addr_i] <= wr_a_i;
      bufb_q[wr_addr_i] <= wr_b_i;
    end
  end

  // Control state, element index, latched length and captured result.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      len_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      len_q   <= len_d;
      res_q   <= res_d;
    end
  end

  // Next-state and output decode; outputs are forced low while reset is held.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    len_d      = len_q;
    res_d      = res_q;
    A_o        = '0;
    B_o        = '0;
    A_v_o      = 1'b0;
    B_v_o      = 1'b0;
    done_acc_o = 1'b0;
    yumi_o     = 1'b0;
    res_v_o    = 1'b0;
    busy_o     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A zero-length request carries no work and is dropped.
        if (start_i && (len_i != '0)) begin
          len_d   = (len_i > MAX_LEN_L) ? MAX_LEN_L : len_i;
          k_d     = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        busy_o = 1'b1;
        A_o    = bufa_q[0];
        B_o    = bufb_q[0];
        A_v_o  = 1'b1;
        B_v_o  = 1'b1;
        if (ready_i) begin
          k_d     = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        busy_o = 1'b1;
        A_o    = bufa_q[k_q];
        B_o    = bufb_q[k_q];
        if (last_elem) begin
          done_acc_o = 1'b1;
          k_d        = '0;
          state_d    = S_WAITRES;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      S_WAITRES: begin
        busy_o = 1'b1;
        yumi_o = v_i;
        if (v_i) begin
          res_d   = accum_i;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        busy_o  = 1'b1;
        res_v_o = 1'b1;
        if (res_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!reset_i) begin
      A_o        = '0;
      B_o        = '0;
      A_v_o      = 1'b0;
      B_v_o      = 1'b0;
      done_acc_o = 1'b0;
      yumi_o     = 1'b0;
      res_v_o    = 1'b0;
      busy_o     = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dot_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dot_feeder
//  Description : Self-checking bench for dot_feeder with a Q8.8 dot-product
//                consumer and a vector-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dot_feeder;

  localparam int MAX_LEN = 8;
  localparam int W       = 16;

  logic          clk;
  logic          reset_i;
  logic          wr_en_i;
  logic [2:0]    wr_addr_i;
  logic [W-1:0]  wr_a_i, wr_b_i;
  logic          start_i;
  logic [3:0]    len_i;
  logic [W-1:0]  A_o, B_o;
  logic          A_v_o, B_v_o;
  logic          ready_i;
  logic          done_acc_o;
  logic [W-1:0]  accum_i;
  logic          v_i;
  logic          yumi_o;
  logic [W-1:0]  res_o;
  logic          res_v_o;
  logic          res_ready_i;
  logic          busy_o;

  int            checks = 0;
  int            errors = 0;

  // Reference vectors and the consumer's running sum.
  logic [W-1:0]  mA [MAX_LEN];
  logic [W-1:0]  mB [MAX_LEN];
  logic [W-1:0]  acc_sum;
  logic [W-1:0]  last_res;

  dot_feeder #(.MAX_LEN(MAX_LEN), .W(W)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_a_i      (wr_a_i),
    .wr_b_i      (wr_b_i),
    .start_i     (start_i),
    .len_i       (len_i),
    .A_o         (A_o),
    .B_o         (B_o),
    .A_v_o       (A_v_o),
    .B_v_o       (B_v_o),
    .ready_i     (ready_i),
    .done_acc_o  (done_acc_o),
    .accum_i     (accum_i),
    .v_i         (v_i),
    .yumi_o      (yumi_o),
    .res_o       (res_o),
    .res_v_o     (res_v_o),
    .res_ready_i (res_ready_i),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Q8.8 product, truncated back to Q8.8.
  function automatic logic [W-1:0] qmul(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[23:8];
  endfunction

  // Write one element pair while idle; called at a negedge, returns at a negedge.
  task automatic write_elem(input int addr, input logic [W-1:0] a, input logic [W-1:0] b);
    wr_en_i   = 1'b1;
    wr_addr_i = addr[2:0];
    wr_a_i    = a;
    wr_b_i    = b;
    mA[addr]  = a;
    mB[addr]  = b;
    @(negedge clk);
    wr_en_i   = 1'b0;
  endtask

  // One full request. Called at a negedge with the DUT idle.
  task automatic run_op(input int len_req, input int rdy_wait, input int v_wait,
                        input int out_wait, input bit clr, input bit ws, input bit inj);
    int eff;
    logic [W-1:0] exp_sum;
    logic [W-1:0] ra, rb;
    eff = (len_req > MAX_LEN) ? MAX_LEN : len_req;
    if (clr) acc_sum = '0;
    // Cycle 0: start request, optionally with a simultaneous write to element 0.
    start_i = 1'b1;
    len_i   = len_req[3:0];
    ready_i = 1'b0;
    if (ws) begin
      ra = W'($urandom); rb = W'($urandom);
      wr_en_i = 1'b1; wr_addr_i = 3'd0; wr_a_i = ra; wr_b_i = rb;
      mA[0] = ra; mB[0] = rb;
    end
    exp_sum = acc_sum;
    for (int i = 0; i < eff; i++) exp_sum = exp_sum + qmul(mA[i], mB[i]);
    #1;
    checks++;
    if ({busy_o, A_v_o, A_o} !== {1'b0, 1'b0, 16'h0}) begin
      errors++; $display("FAIL idle_start: busy/av/A=%b/%b/%h want 0/0/0", busy_o, A_v_o, A_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    wr_en_i = 1'b0;
    // REQ: element 0 presented with valid until ready rises.
    for (int c = 0; c <= rdy_wait; c++) begin
      ready_i = (c == rdy_wait);
      #1;
      checks++;
      if ({A_v_o, B_v_o, busy_o, done_acc_o, A_o, B_o} !== {3'b111, 1'b0, mA[0], mB[0]}) begin
        errors++;
        $display("FAIL req c=%0d: av/bv/busy/done=%b%b%b%b A=%h B=%h want 1110 A=%h B=%h",
                 c, A_v_o, B_v_o, busy_o, done_acc_o, A_o, B_o, mA[0], mB[0]);
      end
      @(negedge clk);
    end
    ready_i = 1'b0;
    // STREAM: one element per cycle, done on the last.
    for (int k = 0; k < eff; k++) begin
      if (inj && k == 0) begin
        wr_en_i = 1'b1; wr_addr_i = 3'd1; wr_a_i = 16'h7FFF; wr_b_i = 16'h7FFF;
      end
      #1;
      checks++;
      if ({A_v_o, B_v_o, yumi_o, done_acc_o, A_o, B_o} !==
          {3'b000, (k == eff - 1), mA[k], mB[k]}) begin
        errors++;
        $display("FAIL stream k=%0d: av/bv/yumi/done=%b%b%b%b A=%h B=%h want 000%b A=%h B=%h",
                 k, A_v_o, B_v_o, yumi_o, done_acc_o, A_o, B_o, (k == eff - 1), mA[k], mB[k]);
      end
      acc_sum = acc_sum + qmul(A_o, B_o);
      @(negedge clk);
      wr_en_i = 1'b0;
    end
    // WAITRES: consumer answers after v_wait cycles; yumi mirrors v_i.
    for (int c = 0; c <= v_wait; c++) begin
      v_i     = (c == v_wait);
      accum_i = acc_sum;
      #1;
      checks++;
      if ({yumi_o, done_acc_o, A_v_o, res_v_o, busy_o, A_o, B_o} !== {v_i, 4'b0001, 32'h0}) begin
        errors++;
        $display("FAIL waitres c=%0d: yumi/done/av/resv/busy=%b%b%b%b%b A=%h want %b0001 A=0",
                 c, yumi_o, done_acc_o, A_v_o, res_v_o, busy_o, A_o, v_i);
      end
      @(negedge clk);
    end
    v_i     = 1'b0;
    accum_i = W'($urandom);
    // OUT: result held until downstream accepts; a start here is ignored.
    for (int c = 0; c <= out_wait; c++) begin
      res_ready_i = (c == out_wait);
      start_i     = (c == 0);
      len_i       = 4'd2;
      #1;
      checks++;
      if ({res_v_o, busy_o, yumi_o, res_o} !== {3'b110, exp_sum}) begin
        errors++;
        $display("FAIL out c=%0d: resv/busy/yumi=%b%b%b res=%h want 110 res=%h",
                 c, res_v_o, busy_o, yumi_o, res_o, exp_sum);
      end
      last_res = res_o;
      @(negedge clk);
      start_i = 1'b0;
    end
    res_ready_i = 1'b0;
    #1;
    checks++;
    if ({busy_o, res_v_o, A_v_o} !== 3'b000) begin
      errors++; $display("FAIL back_idle: busy/resv/av=%b%b%b want 000", busy_o, res_v_o, A_v_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({A_o, B_o, A_v_o, B_v_o, done_acc_o, yumi_o, res_v_o, busy_o, res_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: A=%h B=%h av=%b done=%b yumi=%b resv=%b busy=%b res=%h want 0",
               A_o, B_o, A_v_o, done_acc_o, yumi_o, res_v_o, busy_o, res_o);
    end
    @(negedge clk);
    reset_i = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin mA[i] = '0; mB[i] = '0; end
    acc_sum = '0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    write_elem(0, 16'h0100, 16'h0100);
    write_elem(1, 16'h0200, 16'h0100);
    write_elem(2, 16'h0300, 16'h0100);
    run_op(3, 0, 2, 3, 1'b1, 1'b0, 1'b0);
    checks++;
    if (last_res !== 16'h0600) begin
      errors++; $display("FAIL basic_result: res=%h want 0600", last_res);
    end
  endtask

  task automatic test_len1();
    write_elem(0, 16'h0200, 16'h0080);
    run_op(1, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (last_res !== 16'h0100) begin
      errors++; $display("FAIL len1_result: res=%h want 0100", last_res);
    end
  endtask

  task automatic test_ready_stall();
    write_elem(0, 16'h0123, 16'h0456);
    run_op(2, 5, 1, 1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_len_bounds();
    start_i = 1'b1;
    len_i   = 4'd0;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({busy_o, A_v_o} !== 2'b00) begin
        errors++; $display("FAIL len0 c=%0d: busy/av=%b%b want 00", c, busy_o, A_v_o);
      end
      @(negedge clk);
    end
    for (int i = 0; i < MAX_LEN; i++) write_elem(i, W'($urandom), W'($urandom));
    run_op(9, 1, 0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_write_rules();
    for (int i = 0; i < 3; i++) write_elem(i, W'($urandom_range(0, 16'h03FF)), W'($urandom_range(0, 16'h03FF)));
    run_op(3, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    run_op(3, 0, 1, 0, 1'b1, 1'b0, 1'b0);
    write_elem(1, 16'h7FFF, 16'h7FFF);
    run_op(2, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    run_op(3, 1, 0, 0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 4; i++) write_elem(i, W'($urandom), W'($urandom));
    start_i = 1'b1; len_i = 4'd4; ready_i = 1'b1;
    @(negedge clk);              // REQ
    start_i = 1'b0;
    @(negedge clk);              // STREAM k=0
    ready_i = 1'b0;
    @(negedge clk);              // STREAM k=1
    reset_i = 1'b0;
    #1;
    checks++;
    if ({done_acc_o, yumi_o} !== 2'b00) begin
      errors++; $display("FAIL abort_same: done/yumi=%b%b want 00", done_acc_o, yumi_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({A_o, B_o, A_v_o, B_v_o, done_acc_o, yumi_o, res_v_o, busy_o, res_o} !== '0) begin
      errors++;
      $display("FAIL abort_next: A=%h B=%h av=%b done=%b yumi=%b resv=%b busy=%b res=%h want 0",
               A_o, B_o, A_v_o, done_acc_o, yumi_o, res_v_o, busy_o, res_o);
    end
    @(negedge clk);
    for (int i = 0; i < MAX_LEN; i++) begin mA[i] = '0; mB[i] = '0; end
    reset_i = 1'b1;
    run_op(4, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) write_elem(i, W'($urandom), W'($urandom));
    run_op(4, 0, 1, 1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      for (int j = 0; j < 3; j++) write_elem($urandom_range(0, MAX_LEN - 1), W'($urandom), W'($urandom));
      run_op($urandom_range(1, 11), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_a_i = '0; wr_b_i = '0;
    start_i = 1'b0; len_i = '0; ready_i = 1'b0; accum_i = '0; v_i = 1'b0;
    res_ready_i = 1'b0; acc_sum = '0; last_res = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_len1();
    test_ready_stall();
    test_len_bounds();
    test_write_rules();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dot_feeder.md
DOT_FEEDER -- requirements
Module: dot_feeder

Interface
REQ-001 Parameter MAX_LEN, default 8, meaning vector buffer depth in elements (power of two, minimum 2).
REQ-002 Parameter W, default 16, meaning element and result width (Q8.8 fixed point).
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  reset, synchronous and active-low; sampled on clk_i rising edge.
REQ-005 wr_en_i  input  1  buffer write strobe.
REQ-006 wr_addr_i  input  log2(MAX_LEN)  buffer write index.
REQ-007 wr_a_i, wr_b_i  input  W each  element values written to vector A and vector B buffers.
REQ-008 start_i  input  1  request to stream a dot product.
REQ-009 len_i  input  log2(MAX_LEN)+1  element count for the request.
REQ-010 A_o, B_o  output  W each  element bus to the accumulator.
REQ-011 A_v_o, B_v_o  output  1 each  element-stream request valid (always equal).
REQ-012 ready_i  input  1  accumulator idle/ready.
REQ-013 done_acc_o  output  1  marks the final element cycle.
REQ-014 accum_i  input  W  accumulator result.
REQ-015 v_i  input  1  accumulator result valid.
REQ-016 yumi_o  output  1  result consumed, one-cycle pulse.
REQ-017 res_o  output  W  captured result to downstream.
REQ-018 res_v_o  output  1  res_o valid.
REQ-019 res_ready_i  input  1  downstream accepts res_o.
REQ-020 busy_o  output  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, REQ, STREAM, WAITRES, OUT.
REQ-022 IDLE: start_i with 1 <= len_i <= MAX_LEN -> REQ, latch len; len_i = 0 -> start ignored; len_i > MAX_LEN -> latched as MAX_LEN.
REQ-023 REQ: A_v_o/B_v_o high, A_o/B_o = element 0; ready_i high -> STREAM with index k = 0 next cycle; else hold.
REQ-024 STREAM: A_o = bufA[k], B_o = bufB[k], A_v_o/B_v_o low, k increments every cycle with no stall; exactly len cycles in STREAM.
REQ-025 done_acc_o SHALL be high only in the STREAM cycle where k = len-1, then -> WAITRES; for len = 1, done_acc_o is high in the first STREAM cycle.
REQ-026 WAITRES: yumi_o = v_i combinationally, same cycle; on v_i, accum_i is registered into res_o and state -> OUT.
REQ-027 OUT: res_v_o high, res_o stable; res_ready_i high -> IDLE next cycle; start_i in OUT is ignored.
REQ-028 Outside REQ and STREAM, A_o/B_o SHALL be 0; done_acc_o and yumi_o are 0 in all states not named above.
REQ-029 Buffer writes SHALL be accepted only in IDLE; writes in any other state are dropped and leave contents unchanged.
REQ-030 A write and start_i in the same IDLE cycle SHALL commit the write first, so the streamed data includes it.
REQ-031 res_o SHALL be passed through unmodified: no scaling and no subtraction of earlier sums.
REQ-032 The accumulator sum is cumulative across requests; clearing it is the consumer's responsibility.
REQ-033 Latency, start_i accepted in cycle 0 with ready_i high: REQ in cycle 1, STREAM in cycles 2..len+1, done_acc_o in cycle len+1, WAITRES from cycle len+2.

Reset
REQ-034 While reset_i = 0: state -> IDLE, k -> 0, len -> 0, res_o -> 0, both buffers -> 0.
REQ-035 While reset_i = 0, all outputs (A_o, B_o, A_v_o, B_v_o, done_acc_o, yumi_o, res_v_o, busy_o) SHALL be 0 by the next edge.
REQ-036 Reset asserted in any state, including mid-STREAM, SHALL abort the operation without emitting done_acc_o.
REQ-037 After reset_i returns high, the block SHALL accept start_i in the first cycle.

Verification
REQ-038 Load A = {0x0100,0x0200,0x0300}, B = {0x0100,0x0100,0x0100}; start len 3, ready_i high, paired with a dot_product-behaviour consumer -> STREAM for 3 cycles, done_acc_o on the 3rd, yumi_o one pulse, res_o = 0x0600, res_v_o held until res_ready_i.
REQ-039 Start len 1 with A[0] = 0x0200, B[0] = 0x0080 from a cleared accumulator -> exactly one STREAM cycle with done_acc_o high, res_o = 0x0100.
REQ-040 ready_i held low 5 cycles after start -> REQ held with A_v_o high and A_o = element 0 throughout; streaming starts only the cycle after ready_i rises.
REQ-041 len_i = 0 -> busy_o stays 0; len_i = 9 with MAX_LEN = 8 -> exactly 8 STREAM cycles.
REQ-042 wr_en_i pulsed mid-STREAM at addr 1 with 0x7FFF -> streamed and later values unchanged; the same write in IDLE updates element 1.
REQ-043 reset_i driven low in the 2nd STREAM cycle -> next cycle all outputs 0, no done_acc_o or yumi_o; a new start then completes normally.
